// File: rtl/rts_pkg.sv
// Shared state encoding, reset values and default widths for the RTS BIST controller.
package rts_pkg;

    localparam int unsigned DEF_NUM_CHAINS = 4;
    localparam int unsigned DEF_SHIFT_W    = 8;
    localparam int unsigned DEF_ROUND_W    = 16;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_INIT    = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_FLUSH   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

    localparam logic RST_INTERNAL_RST = 1'b1;
    localparam logic RST_NBART        = 1'b0;
    localparam logic RST_EN           = 1'b0;

    // FLUSH drives exactly the same scan outputs as SHIFT.
    function automatic logic is_scan_state(input logic [STATE_W-1:0] st);
        return (st == ST_SHIFT) || (st == ST_FLUSH);
    endfunction

endpackage

// File: rtl/rts_down_counter.sv
// Loadable down-counter that times the shift phase; stops at zero instead of wrapping.
module rts_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/rts_multichain_controller.sv
// RTS BIST sequencer: init, shift and capture phases over a runtime number of rounds.
// Optional build macro RTS_FLUSH_EN adds a final unload (FLUSH) phase before DONE.
module rts_multichain_controller
    import rts_pkg::*;
#(
    parameter int unsigned NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int unsigned SHIFT_W    = DEF_SHIFT_W,
    parameter int unsigned ROUND_W    = DEF_ROUND_W
) (
    input  logic                  clk,
    input  logic                  masterRst_n,
    input  logic                  start,
    input  logic [SHIFT_W-1:0]    shift_len,
    input  logic [ROUND_W-1:0]    num_rounds,
    input  logic [NUM_CHAINS-1:0] chain_mask,
    output logic                  internalRst,
    output logic                  NbarT,
    output logic                  PRPG_En,
    output logic                  MISR_En,
    output logic [NUM_CHAINS-1:0] SRSG_En,
    output logic [NUM_CHAINS-1:0] SISA_En,
    output logic                  busy,
    output logic                  done,
    output logic [ROUND_W-1:0]    round_cnt
);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_d;

    logic [SHIFT_W-1:0]    r_shift_len;
    logic [ROUND_W-1:0]    r_num_rounds;
    logic [NUM_CHAINS-1:0] r_mask;
    logic [ROUND_W-1:0]    r_round_cnt;

    logic                  r_internal_rst;
    logic                  r_nbart;
    logic                  r_prpg_en;
    logic                  r_misr_en;
    logic [NUM_CHAINS-1:0] r_srsg_en;
    logic [NUM_CHAINS-1:0] r_sisa_en;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;
    logic                  w_cnt_one;
    logic                  w_shift_end;
    logic                  w_last_round;
    logic                  w_scan_d;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_cnt_load   = (r_state == ST_INIT) || (r_state == ST_CAPTURE);
    assign w_cnt_dec    = is_scan_state(r_state);
    // Zero is never reached inside a scan phase; treated as an end for robustness.
    assign w_shift_end  = w_cnt_one || w_cnt_zero;
    assign w_last_round = (r_round_cnt == (r_num_rounds - ROUND_W'(1)));

    rts_down_counter #(
        .W (SHIFT_W)
    ) u_shift_cnt (
        .i_clk      (clk),
        .i_rst_n    (masterRst_n),
        .i_load     (w_cnt_load),
        .i_load_val (r_shift_len),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_d = ST_INIT;
            end
            ST_INIT: begin
                if (r_num_rounds == '0)     w_state_d = ST_DONE;
                else if (r_shift_len == '0) w_state_d = ST_CAPTURE;
                else                        w_state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_shift_end) w_state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_last_round) begin
`ifdef RTS_FLUSH_EN
                    w_state_d = (r_shift_len == '0) ? ST_DONE : ST_FLUSH;
`else
                    w_state_d = ST_DONE;
`endif
                end else if (r_shift_len == '0) begin
                    w_state_d = ST_CAPTURE;
                end else begin
                    w_state_d = ST_SHIFT;
                end
            end
`ifdef RTS_FLUSH_EN
            ST_FLUSH: begin
                if (w_shift_end) w_state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign w_scan_d = is_scan_state(w_state_d);

    always_ff @(posedge clk or negedge masterRst_n) begin
        if (!masterRst_n) begin
            r_state      <= ST_IDLE;
            r_shift_len  <= '0;
            r_num_rounds <= '0;
            r_mask       <= '0;
            r_round_cnt  <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_shift_len  <= shift_len;
                r_num_rounds <= num_rounds;
                r_mask       <= chain_mask;
                r_round_cnt  <= '0;
            end else if ((r_state == ST_CAPTURE) && (r_round_cnt != r_num_rounds)) begin
                r_round_cnt <= r_round_cnt + ROUND_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge masterRst_n) begin
        if (!masterRst_n) begin
            r_internal_rst <= RST_INTERNAL_RST;
            r_nbart        <= RST_NBART;
            r_prpg_en      <= RST_EN;
            r_misr_en      <= RST_EN;
            r_srsg_en      <= {NUM_CHAINS{RST_EN}};
            r_sisa_en      <= {NUM_CHAINS{RST_EN}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_internal_rst <= (w_state_d == ST_INIT);
            r_nbart        <= w_scan_d;
            r_prpg_en      <= (w_state_d == ST_CAPTURE);
            r_misr_en      <= (w_state_d == ST_CAPTURE);
            r_srsg_en      <= w_scan_d ? r_mask : '0;
            r_sisa_en      <= w_scan_d ? r_mask : '0;
            r_busy         <= (w_state_d != ST_IDLE);
            r_done         <= (w_state_d == ST_DONE);
        end
    end

    assign internalRst = r_internal_rst;
    assign NbarT       = r_nbart;
    assign PRPG_En     = r_prpg_en;
    assign MISR_En     = r_misr_en;
    assign SRSG_En     = r_srsg_en;
    assign SISA_En     = r_sisa_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign round_cnt   = r_round_cnt;

endmodule

// File: tb/tb_rts_multichain_controller.sv
// Scoreboard bench: per-cycle expected outputs are queued at start and compared as the session runs.
module tb_rts_multichain_controller;

    typedef struct packed {
        logic        irst;
        logic        nbart;
        logic        prpg;
        logic        misr;
        logic [3:0]  srsg;
        logic [3:0]  sisa;
        logic        busy;
        logic        done;
        logic [15:0] rc;
    } exp_t;

    logic        clk;
    logic        masterRst_n;
    logic        start;
    logic [7:0]  shift_len;
    logic [15:0] num_rounds;
    logic [3:0]  chain_mask;
    logic        internalRst;
    logic        NbarT;
    logic        PRPG_En;
    logic        MISR_En;
    logic [3:0]  SRSG_En;
    logic [3:0]  SISA_En;
    logic        busy;
    logic        done;
    logic [15:0] round_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rts_multichain_controller dut (
        .clk         (clk),
        .masterRst_n (masterRst_n),
        .start       (start),
        .shift_len   (shift_len),
        .num_rounds  (num_rounds),
        .chain_mask  (chain_mask),
        .internalRst (internalRst),
        .NbarT       (NbarT),
        .PRPG_En     (PRPG_En),
        .MISR_En     (MISR_En),
        .SRSG_En     (SRSG_En),
        .SISA_En     (SISA_En),
        .busy        (busy),
        .done        (done),
        .round_cnt   (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic irst, input logic nbart, input logic cap,
                                input logic [3:0] en, input logic bsy, input logic dn,
                                input logic [15:0] rc);
        exp_t e;
        e.irst  = irst;
        e.nbart = nbart;
        e.prpg  = cap;
        e.misr  = cap;
        e.srsg  = en;
        e.sisa  = en;
        e.busy  = bsy;
        e.done  = dn;
        e.rc    = rc;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t exp);
        exp_t got;
        got = {internalRst, NbarT, PRPG_En, MISR_En, SRSG_En, SISA_En, busy, done, round_cnt};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Queue the whole expected session, pulse start, then compare every cycle.
    task automatic run_session(input string tag, input int len, input int rounds,
                               input logic [3:0] mask, input bit noisy, input int stop_after);
        int   rc;
        int   n;
        exp_t e;
        rc = 0;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd0));
        for (int r = 0; r < rounds; r++) begin
            for (int s = 0; s < len; s++)
                sb.push_back(mk(1'b0, 1'b1, 1'b0, mask, 1'b1, 1'b0, 16'(rc)));
            sb.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 16'(rc)));
            rc++;
        end
`ifdef RTS_FLUSH_EN
        if (rounds > 0) begin
            for (int s = 0; s < len; s++)
                sb.push_back(mk(1'b0, 1'b1, 1'b0, mask, 1'b1, 1'b0, 16'(rc)));
        end
`endif
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 16'(rc)));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'(rc)));

        shift_len  = len[7:0];
        num_rounds = rounds[15:0];
        chain_mask = mask;
        start      = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, e);
            n++;
            if (stop_after > 0 && n >= stop_after) begin
                sb.delete();
                break;
            end
            if (noisy) begin
                // Hammer start with junk config while busy (including the DONE cycle).
                start      = e.busy;
                shift_len  = 8'($urandom);
                num_rounds = 16'($urandom);
                chain_mask = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        masterRst_n = 1'b0;
        start       = 1'b0;
        shift_len   = 8'd0;
        num_rounds  = 16'd0;
        chain_mask  = 4'd0;

        @(posedge clk);
        #1;
        check("reset_hold0", mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));
        @(posedge clk);
        #1;
        check("reset_hold1", mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));
        masterRst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));

        run_session("l3_r2_m1011", 3, 2, 4'b1011, 1'b0, 0);
        run_session("r0", 5, 0, 4'b1111, 1'b0, 0);
        run_session("l0_r4", 0, 4, 4'b1111, 1'b0, 0);
        run_session("mask0", 2, 2, 4'b0000, 1'b0, 0);
        run_session("start_noise", 2, 3, 4'b0110, 1'b1, 0);
        run_session("l2_r1", 2, 1, 4'b1100, 1'b0, 0);

        // Abort in round 2 of an L=8,R=5 session: INIT + 9 cycles of round 1 + 4 shifts.
        run_session("abort_pre", 8, 5, 4'b0101, 1'b0, 14);
        masterRst_n = 1'b0;
        #1;
        check("abort_async", mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));
        @(posedge clk);
        #1;
        check("abort_hold", mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));
        masterRst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle", mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0));
        run_session("after_abort_l1_r1", 1, 1, 4'b1111, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
